// File: rtl/register_storage_pkg.sv
// Shared encodings for the register-storage family: manual op codes,
// burst direction values and the burst controller state type.
package register_storage_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_SHR  = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_t;

endpackage

// File: rtl/register_storage_burst_ctrl.sv
// Burst sequencer: accepts a start request, counts enabled shift edges,
// and reports busy / a one-cycle done pulse plus the captured shift setup.
module register_storage_burst_ctrl
  import register_storage_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             burst_start,
  input  logic             burst_dir,
  input  logic             rotate,
  input  logic [CNT_W-1:0] burst_len,
  output logic             busy,
  output logic             burst_done,
  output logic             burst_shift,
  output logic             shift_dir,
  output logic             shift_rotate
);

  burst_state_t     state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             done_next, dir_next, rot_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      count        <= '0;
      burst_done   <= 1'b0;
      shift_dir    <= DIR_LEFT;
      shift_rotate <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      burst_done   <= done_next;
      shift_dir    <= dir_next;
      shift_rotate <= rot_next;
    end
  end

  // A zero-length request completes immediately without entering BURST.
  always_comb begin
    state_next = state;
    count_next = count;
    done_next  = 1'b0;
    dir_next   = shift_dir;
    rot_next   = shift_rotate;
    if (clear) begin
      state_next = ST_IDLE;
      count_next = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (burst_start) begin
            if (burst_len != '0) begin
              state_next = ST_BURST;
              count_next = burst_len;
              dir_next   = burst_dir;
              rot_next   = rotate;
            end else begin
              done_next  = 1'b1;
            end
          end
        end
        ST_BURST: begin
          if (enable) begin
            count_next = count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state == ST_BURST);
    burst_shift = (state == ST_BURST) && enable && !clear;
  end

endmodule

// File: rtl/register_storage_universal_shift.sv
// Universal shift/storage register: hold, load, shift left/right with
// optional rotate, plus an autonomous counted burst of shifts.
module register_storage_universal_shift
  import register_storage_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             burst_start,
  input  logic             burst_dir,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_msb,
  output logic             serial_out_lsb,
  output logic             busy,
  output logic             burst_done
);

  logic [WIDTH-1:0] word_next;
  logic             burst_shift, shift_dir, shift_rotate;

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w,
                                                  input logic dir,
                                                  input logic rot,
                                                  input logic sin);
    logic fill;
    if (dir == DIR_RIGHT) begin
      fill = rot ? w[0] : sin;
      return {fill, w[WIDTH-1:1]};
    end else begin
      fill = rot ? w[WIDTH-1] : sin;
      return {w[WIDTH-2:0], fill};
    end
  endfunction

  register_storage_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .enable       (enable),
    .burst_start  (burst_start),
    .burst_dir    (burst_dir),
    .rotate       (rotate),
    .burst_len    (burst_len),
    .busy         (busy),
    .burst_done   (burst_done),
    .burst_shift  (burst_shift),
    .shift_dir    (shift_dir),
    .shift_rotate (shift_rotate)
  );

  // Priority: clear, then burst activity, then manual mode. A start edge
  // (accepted or zero-length) performs no data operation.
  always_comb begin
    word_next = parallel_out;
    if (clear) begin
      word_next = '0;
    end else if (busy) begin
      if (burst_shift) word_next = shift_word(parallel_out, shift_dir, shift_rotate, serial_in);
    end else if (!burst_start && enable) begin
      unique case (mode)
        MODE_HOLD: word_next = parallel_out;
        MODE_LOAD: word_next = parallel_in;
        MODE_SHL:  word_next = shift_word(parallel_out, DIR_LEFT, rotate, serial_in);
        MODE_SHR:  word_next = shift_word(parallel_out, DIR_RIGHT, rotate, serial_in);
        default:   word_next = parallel_out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parallel_out <= '0;
    else        parallel_out <= word_next;
  end

  assign serial_out_msb = parallel_out[WIDTH-1];
  assign serial_out_lsb = parallel_out[0];

endmodule

// File: tb/tb_register_storage_universal_shift.sv
// Bench for the universal shift register: directed scenarios with literal
// expectations, then randomized traffic against an arithmetic reference model.
module tb_register_storage_universal_shift;

  logic       clk = 1'b0;
  logic       rst_n, clear, enable, rotate, serial_in, burst_start, burst_dir;
  logic [1:0] mode;
  logic [7:0] parallel_in;
  logic [3:0] burst_len;
  logic [7:0] parallel_out;
  logic       serial_out_msb, serial_out_lsb, busy, burst_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_word, m_rem;
  bit m_busy, m_done, m_dir, m_rot;

  register_storage_universal_shift #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .enable(enable), .mode(mode),
    .rotate(rotate), .serial_in(serial_in), .parallel_in(parallel_in),
    .burst_start(burst_start), .burst_dir(burst_dir), .burst_len(burst_len),
    .parallel_out(parallel_out), .serial_out_msb(serial_out_msb),
    .serial_out_lsb(serial_out_lsb), .busy(busy), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  function automatic int m_shift(int w, bit right, bit rot, bit sin);
    int fill;
    if (right) begin
      fill = rot ? (w % 2) : int'(sin);
      return (w / 2) + fill * 128;
    end
    fill = rot ? (w / 128) : int'(sin);
    return ((w * 2) % 256) + fill;
  endfunction

  function automatic void model_reset();
    m_word = 0; m_rem = 0; m_busy = 0; m_done = 0; m_dir = 0; m_rot = 0;
  endfunction

  function automatic void model_edge();
    bit nd = 0;
    if (clear) begin
      m_word = 0; m_busy = 0; m_rem = 0;
    end else if (m_busy) begin
      if (enable) begin
        m_word = m_shift(m_word, m_dir, m_rot, serial_in);
        m_rem--;
        if (m_rem == 0) begin m_busy = 0; nd = 1; end
      end
    end else if (burst_start) begin
      if (burst_len != 0) begin
        m_busy = 1; m_rem = burst_len; m_dir = burst_dir; m_rot = rotate;
      end else nd = 1;
    end else if (enable) begin
      case (mode)
        2'b01: m_word = parallel_in;
        2'b10: m_word = m_shift(m_word, 0, rotate, serial_in);
        2'b11: m_word = m_shift(m_word, 1, rotate, serial_in);
        default: ;
      endcase
    end
    m_done = nd;
  endfunction

  task automatic quiet();
    clear = 0; enable = 0; mode = 2'b00; rotate = 0; serial_in = 0;
    parallel_in = 8'h00; burst_start = 0; burst_dir = 0; burst_len = 4'd0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    quiet(); enable = 1; mode = 2'b01; parallel_in = v;
    tick();
    quiet();
  endtask

  task automatic async_reset();
    #2 rst_n = 0;
    #1;
    model_reset();
    n_checks++;
    if (parallel_out !== 8'h00 || busy !== 1'b0 || burst_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: out=%h busy=%b done=%b required out=00 busy=0 done=0",
               parallel_out, busy, burst_done);
    end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    quiet(); rst_n = 0;
    @(posedge clk); #1;
    model_reset();
    n_checks++;
    if (parallel_out !== 8'h00 || busy !== 1'b0 || burst_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: out=%h busy=%b done=%b required 00/0/0", parallel_out, busy, burst_done);
    end
    rst_n = 1;
    load(8'h3C);
    async_reset();
  endtask

  task automatic test_manual();
    logic [7:0] expv [4] = '{8'h4B, 8'h52, 8'hD2, 8'h4B};
    logic [1:0] mds  [4] = '{2'b10, 2'b11, 2'b11, 2'b10};
    logic       rots [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       sins [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    load(8'hA5);
    n_checks++;
    if (parallel_out !== 8'hA5) begin
      n_fail++; $display("FAIL load: out=%h required A5", parallel_out);
    end
    mode = 2'b01; parallel_in = 8'hFF; enable = 0;
    tick();
    n_checks++;
    if (parallel_out !== 8'hA5) begin
      n_fail++; $display("FAIL enable_hold: out=%h required A5", parallel_out);
    end
    for (int i = 0; i < 4; i++) begin
      load(8'hA5);
      enable = 1; mode = mds[i]; rotate = rots[i]; serial_in = sins[i];
      tick();
      quiet();
      n_checks++;
      if (parallel_out !== expv[i] || serial_out_msb !== expv[i][7] || serial_out_lsb !== expv[i][0]) begin
        n_fail++;
        $display("FAIL manual_shift%0d: out=%h msb=%b lsb=%b required %h", i, parallel_out,
                 serial_out_msb, serial_out_lsb, expv[i]);
      end
    end
  endtask

  task automatic test_burst();
    logic [7:0] expv [3] = '{8'h40, 8'h20, 8'h10};
    load(8'h81);
    burst_start = 1; burst_len = 4'd3; burst_dir = 1; rotate = 0; serial_in = 0;
    tick();
    quiet();
    n_checks++;
    if (parallel_out !== 8'h81 || busy !== 1'b1 || burst_done !== 1'b0) begin
      n_fail++; $display("FAIL burst_start: out=%h busy=%b done=%b required 81/1/0", parallel_out, busy, burst_done);
    end
    for (int i = 0; i < 3; i++) begin
      enable = 1;
      if (i == 0) begin burst_start = 1; burst_len = 4'd5; burst_dir = 0; mode = 2'b01; parallel_in = 8'hEE; end
      tick();
      quiet();
      n_checks++;
      if (parallel_out !== expv[i] || busy !== (i != 2) || burst_done !== (i == 2)) begin
        n_fail++;
        $display("FAIL burst_shift%0d: out=%h busy=%b done=%b required %h/%b/%b", i, parallel_out,
                 busy, burst_done, expv[i], i != 2, i == 2);
      end
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || burst_done !== 1'b0 || parallel_out !== 8'h10) begin
      n_fail++; $display("FAIL burst_after: out=%h busy=%b done=%b required 10/0/0", parallel_out, busy, burst_done);
    end
  endtask

  task automatic test_stall_rotate();
    int dones = 0;
    load(8'h81);
    burst_start = 1; burst_len = 4'd2; burst_dir = 0; rotate = 1;
    tick();
    quiet();
    enable = 1; serial_in = 0; tick();
    n_checks++;
    if (parallel_out !== 8'h03 || busy !== 1'b1) begin
      n_fail++; $display("FAIL stall_first: out=%h busy=%b required 03/1", parallel_out, busy);
    end
    enable = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      dones += burst_done;
      n_checks++;
      if (parallel_out !== 8'h03 || busy !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold%0d: out=%h busy=%b required 03/1", i, parallel_out, busy);
      end
    end
    enable = 1; tick(); dones += burst_done;
    quiet(); tick(); dones += burst_done;
    n_checks++;
    if (parallel_out !== 8'h06 || busy !== 1'b0 || dones != 1) begin
      n_fail++; $display("FAIL stall_final: out=%h busy=%b done_pulses=%0d required 06/0/1", parallel_out, busy, dones);
    end
  endtask

  task automatic test_abort();
    load(8'h81);
    burst_start = 1; burst_len = 4'd3; burst_dir = 1;
    tick();
    quiet(); enable = 1; tick();
    clear = 1; tick();
    quiet();
    n_checks++;
    if (parallel_out !== 8'h00 || busy !== 1'b0 || burst_done !== 1'b0) begin
      n_fail++; $display("FAIL abort: out=%h busy=%b done=%b required 00/0/0", parallel_out, busy, burst_done);
    end
    load(8'h5A);
    burst_start = 1; burst_len = 4'd0; enable = 1; mode = 2'b10;
    tick();
    quiet();
    n_checks++;
    if (parallel_out !== 8'h5A || busy !== 1'b0 || burst_done !== 1'b1) begin
      n_fail++; $display("FAIL zero_len: out=%h busy=%b done=%b required 5A/0/1", parallel_out, busy, burst_done);
    end
    tick();
    n_checks++;
    if (burst_done !== 1'b0) begin
      n_fail++; $display("FAIL zero_len_pulse: done=%b required 0", burst_done);
    end
  endtask

  task automatic test_back_to_back();
    load(8'h0F);
    burst_start = 1; burst_len = 4'd1; burst_dir = 0; rotate = 0;
    tick();
    quiet(); enable = 1; serial_in = 1; tick();
    n_checks++;
    if (parallel_out !== 8'h1F || burst_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first: out=%h done=%b busy=%b required 1F/1/0", parallel_out, burst_done, busy);
    end
    burst_start = 1; burst_len = 4'd4; burst_dir = 1;
    tick();
    burst_start = 0;
    n_checks++;
    if (busy !== 1'b1 || burst_done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: busy=%b done=%b required 1/0", busy, burst_done);
    end
    tick();
    async_reset();
    quiet(); load(8'h77);
    n_checks++;
    if (parallel_out !== 8'h77 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: out=%h busy=%b required 77/0", parallel_out, busy);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clear       = ($urandom_range(0, 39) == 0);
      enable      = ($urandom_range(0, 3) != 0);
      mode        = 2'($urandom_range(0, 3));
      rotate      = 1'($urandom_range(0, 1));
      serial_in   = 1'($urandom_range(0, 1));
      parallel_in = 8'($urandom);
      burst_start = ($urandom_range(0, 7) == 0);
      burst_dir   = 1'($urandom_range(0, 1));
      burst_len   = 4'($urandom_range(0, 15));
      tick();
      n_checks++;
      if (parallel_out !== 8'(m_word) || busy !== m_busy || burst_done !== m_done ||
          serial_out_msb !== (m_word >= 128) || serial_out_lsb !== 1'(m_word % 2)) begin
        n_fail++;
        $display("FAIL random%0d: out=%h busy=%b done=%b msb=%b lsb=%b required %h/%b/%b", c,
                 parallel_out, busy, burst_done, serial_out_msb, serial_out_lsb, 8'(m_word), m_busy, m_done);
      end
    end
    quiet();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_manual();
    test_burst();
    test_stall_rotate();
    test_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_storage_universal_shift.md
Name: register_storage_universal_shift

Overview:
- Parametrised successor to the 4-bit PIPO storage register.
- Holds a WIDTH-bit word and supports hold, parallel load, shift left and shift right, each with optional rotate.
- Adds an autonomous burst engine: a single start request shifts the word a programmed number of times, with busy/done handshake.
- Used as a general storage/serialiser element in the register-storage family.

Parameters:
- WIDTH, 8: data word width in bits (>= 2).
- CNT_W, 4: width of the burst length field; max burst = 2^CNT_W-1 shifts.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear, active high
- enable  in  1  advances manual ops and burst shifts
- mode  in  2  manual op: 00 hold, 01 load, 10 shift left, 11 shift right
- rotate  in  1  shifts recirculate the ejected bit instead of taking serial_in
- serial_in  in  1  fill bit for the vacated position on non-rotate shifts
- parallel_in  in  WIDTH  load data
- burst_start  in  1  request a burst (single-cycle pulse expected)
- burst_dir  in  1  burst direction: 0 left, 1 right
- burst_len  in  CNT_W  number of burst shifts
- parallel_out  out  WIDTH  stored word, registered
- serial_out_msb  out  1  parallel_out[WIDTH-1]
- serial_out_lsb  out  1  parallel_out[0]
- busy  out  1  burst in progress, registered
- burst_done  out  1  one-cycle pulse when a burst completes, registered

Behaviour:
- Reset (rst_n low, asynchronous): parallel_out=0, busy=0, burst_done=0, counter=0, FSM=IDLE. Outputs go to zero immediately, not at the next edge.
- Per-edge priority: clear > burst activity > manual mode.
- clear=1: parallel_out=0, FSM→IDLE, busy=0, burst_done=0. This applies regardless of enable or FSM state. Clearing mid-burst aborts the burst with no done pulse.
- Shift left: out <= {out[WIDTH-2:0], fill}, where fill = rotate ? out[WIDTH-1] : serial_in.
- Shift right: out <= {fill, out[WIDTH-1:1]}, where fill = rotate ? out[0] : serial_in.
- Manual ops (IDLE, no burst_start, enable=1): apply mode. All results are visible after the edge (1-cycle latency). enable=0 holds.
- FSM states: IDLE, BURST.
- IDLE → BURST: on an edge with burst_start=1 and burst_len!=0, regardless of enable.
  - Capture burst_dir and rotate; load counter=burst_len; busy=1.
  - No data operation occurs on the start edge; mode is ignored.
- IDLE with burst_start=1 and burst_len=0: no shift, stay IDLE, burst_done=1 for the following cycle.
- BURST operation: each edge with enable=1 performs one shift in the captured direction/rotate and decrements the counter. serial_in is sampled live at each shift.
  - enable=0 stalls: no shift, counter holds, busy stays 1.
- BURST → IDLE: on the edge performing the final shift (counter==1). At that edge busy→0 and burst_done→1 for exactly one cycle.
  - Result: busy is high for exactly burst_len enabled shift edges; done rises on the same edge busy falls.
- During BURST, mode, parallel_in, burst_start and burst_dir are ignored. A burst_start while busy is dropped, not queued.
- Back-to-back: burst_start may be asserted in the cycle burst_done is high; it is accepted from IDLE.
- burst_len > WIDTH is legal: the word shifts past full width (zeros or serial fill, or full rotation).
- serial_out_msb and serial_out_lsb are combinational slices of the registered word.

Decomposition:
- Shared package register_storage_pkg: mode encodings (MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR), DIR_LEFT/DIR_RIGHT, and the FSM state enum (ST_IDLE, ST_BURST).
- One natural sub-module, register_storage_burst_ctrl: FSM, counter, busy/done, and a captured-direction output. The top holds the data register and shift datapath.

Test Plan (WIDTH=8, CNT_W=4):
- Reset/manual load: rst_n low asynchronously mid-cycle → out=00 immediately. Release, load A5 (mode=01, enable=1) → out=A5 next cycle. enable=0 with mode=01, parallel_in=FF → stays A5.
- Manual shifts from A5:
  - shl, serial_in=1 → 4B
  - shr, serial_in=0 → 52
  - rotate right → D2
  - rotate left → 4B
  - serial_out_msb/serial_out_lsb track bits 7/0 each cycle.
- Burst: from 81, burst_start with len=3, dir=right, rotate=0, serial_in=0 → shift results 40, 20, 10. busy high 3 cycles, burst_done one pulse at final edge. A burst_start during busy is ignored.
- Stall and rotate: from 81, len=2, dir=left, rotate=1, with enable dropped for 2 cycles mid-burst → final 06. busy is extended by the 2 stall cycles; single done pulse.
- Abort: clear asserted on the 2nd burst shift edge → out=00, busy=0, no burst_done. A next start with len=0 → done pulse one cycle later, out unchanged.
- Back-to-back: a new burst_start in the done cycle is accepted. Async reset mid-burst → all outputs 0 and FSM idle.
